// File: rtl/phy_rx_pkg.sv
// phy_rx_pkg: shared constants and lane FSM encoding for the PHY receive link controller
package phy_rx_pkg;
  localparam int SYM_W = 8;
  localparam logic [SYM_W-1:0] COM_SYMBOL_DEFAULT = 8'hBC;
  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } lane_st_e;
endpackage

// File: rtl/phy_rx_lane_align.sv
// phy_rx_lane_align: per-lane COM search, symbol alignment and lock tracking
module phy_rx_lane_align
  import phy_rx_pkg::*;
#(
  parameter logic [SYM_W-1:0] COM_SYMBOL = COM_SYMBOL_DEFAULT,
  parameter int LOCK_COUNT = 4,
  parameter int MAX_GAP = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             din_i,
  output logic             locked_o,
  output logic             boundary_o,
  output logic             lost_o,
  output logic [SYM_W-1:0] sym_o,
  output logic [SYM_W-1:0] sr_o
);
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int GW = $clog2(MAX_GAP + 1);
  localparam logic [CW-1:0] COM_LIM = CW'(LOCK_COUNT);
  localparam logic [GW-1:0] GAP_LIM = GW'(MAX_GAP);
  lane_st_e state_q, state_d;
  logic [SYM_W-1:0] sr_q, sr_d, sym_q, sym_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] com_cnt_q, com_cnt_d, com_inc;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d, gap_inc;
  logic is_com;
  assign is_com = sr_q == COM_SYMBOL;
  assign com_inc = com_cnt_q + CW'(1);
  assign gap_inc = gap_cnt_q + GW'(1);
  assign boundary_o = bit_cnt_q == 3'd7;
  assign locked_o = state_q == ST_LOCKED;
  assign lost_o = (state_q == ST_LOCKED) && (state_d == ST_SEARCH);
  assign sym_o = sym_q;
  assign sr_o = sr_q;
  // Lane state register: shifter, phase counter, FSM and its counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_SEARCH;
      sr_q      <= '0;
      sym_q     <= '0;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      sym_q     <= sym_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end
  // Next state: SEARCH matches bit by bit, ALIGN/LOCKED only judge symbols at boundaries
  always_comb begin
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    gap_cnt_d = gap_cnt_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    sr_d      = {sr_q[SYM_W-2:0], din_i};
    sym_d     = boundary_o ? sr_q : sym_q;
    unique case (state_q)
      ST_SEARCH: begin
        if (is_com) begin
          state_d   = ST_ALIGN;
          bit_cnt_d = 3'd0;
          com_cnt_d = CW'(1);
        end
      end
      ST_ALIGN: begin
        if (boundary_o) begin
          if (is_com) begin
            com_cnt_d = com_inc;
            gap_cnt_d = '0;
            state_d   = (com_inc == COM_LIM) ? ST_LOCKED : ST_ALIGN;
          end else begin
            state_d   = ST_SEARCH;
            com_cnt_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (boundary_o) begin
          if (is_com) begin
            gap_cnt_d = '0;
          end else if (gap_inc == GAP_LIM) begin
            state_d   = ST_SEARCH;
            gap_cnt_d = '0;
            com_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_inc;
          end
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end
endmodule

// File: rtl/phy_rx_link_ctrl.sv
// phy_rx_link_ctrl: two-lane receive link controller with symbol pairing and lock-loss counting
module phy_rx_link_ctrl
  import phy_rx_pkg::*;
#(
  parameter logic [SYM_W-1:0] COM_SYMBOL = COM_SYMBOL_DEFAULT,
  parameter int LOCK_COUNT = 4,
  parameter int MAX_GAP = 16
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        data_in_0,
  input  logic        data_in_1,
  output logic [1:0]  lock,
  output logic        link_up,
  output logic        sym_strobe,
  output logic [15:0] sym_out,
  output logic        data_valid,
  output logic [7:0]  err_cnt
);
  logic [1:0] din, bnd, lost;
  logic [SYM_W-1:0] sym [2];
  logic [SYM_W-1:0] sr [2];
  logic stb_q, stb_d, dv_q, dv_d;
  logic [15:0] sym_out_q, sym_out_d;
  logic [7:0] err_q, err_d;
  logic [8:0] err_sum;
  logic unused_lane_bits;
  assign din = {data_in_1, data_in_0};
  for (genvar i = 0; i < 2; i++) begin : g_lane
    phy_rx_lane_align #(
      .COM_SYMBOL(COM_SYMBOL),
      .LOCK_COUNT(LOCK_COUNT),
      .MAX_GAP(MAX_GAP)
    ) u_lane (
      .clk_i(clk_32f),
      .rst_i(reset),
      .din_i(din[i]),
      .locked_o(lock[i]),
      .boundary_o(bnd[i]),
      .lost_o(lost[i]),
      .sym_o(sym[i]),
      .sr_o(sr[i])
    );
  end
  assign unused_lane_bits = ^{bnd[1], sr[1], sym[0]};
  assign link_up = &lock;
  assign sym_strobe = stb_q;
  assign data_valid = dv_q;
  assign sym_out = sym_out_q;
  assign err_cnt = err_q;
  // Output registers
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      stb_q     <= 1'b0;
      dv_q      <= 1'b0;
      sym_out_q <= '0;
      err_q     <= '0;
    end else begin
      stb_q     <= stb_d;
      dv_q      <= dv_d;
      sym_out_q <= sym_out_d;
      err_q     <= err_d;
    end
  end
  // Strobe only on lane-0 boundaries where the link stays up; lock losses add saturating
  always_comb begin
    stb_d     = bnd[0] & link_up & ~|lost;
    dv_d      = stb_d & (sr[0] != COM_SYMBOL) & (sym[1] != COM_SYMBOL);
    sym_out_d = stb_d ? {sym[1], sr[0]} : sym_out_q;
    err_sum   = {1'b0, err_q} + {8'd0, lost[0]} + {8'd0, lost[1]};
    err_d     = err_sum[8] ? 8'hFF : err_sum[7:0];
  end
endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// tb_phy_rx_link_ctrl: directed vector bench for the two-lane receive link controller
module tb_phy_rx_link_ctrl;
  logic clk_32f = 1'b0;
  logic reset = 1'b1;
  logic data_in_0 = 1'b0;
  logic data_in_1 = 1'b0;
  logic [1:0] lock;
  logic link_up, sym_strobe, data_valid;
  logic [15:0] sym_out;
  logic [7:0] err_cnt;
  typedef struct {
    int id;
    int n;
    logic [1:0] lock;
    logic link;
    logic stb;
    logic [15:0] sym;
    logic dv;
    logic [7:0] err;
  } vec_t;
  vec_t vec[$];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  always #5 clk_32f = ~clk_32f;
  phy_rx_link_ctrl dut (
    .clk_32f(clk_32f),
    .reset(reset),
    .data_in_0(data_in_0),
    .data_in_1(data_in_1),
    .lock(lock),
    .link_up(link_up),
    .sym_strobe(sym_strobe),
    .sym_out(sym_out),
    .data_valid(data_valid),
    .err_cnt(err_cnt)
  );
  task automatic add(input int id, input int n, input logic [1:0] lk, input logic ln, input logic sb,
                     input logic [15:0] sy, input logic dv, input logic [7:0] er);
    vec_t v;
    v.id = id; v.n = n; v.lock = lk; v.link = ln; v.stb = sb; v.sym = sy; v.dv = dv; v.err = er;
    vec.push_back(v);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (lock,link,stb,sym,dv,err packed)", name, act, exp);
  endtask
  function automatic logic [31:0] outs();
    return {3'b0, lock, link_up, sym_strobe, sym_out, data_valid, err_cnt};
  endfunction
  function automatic logic bit_at(input int lane, input int i);
    logic [7:0] b;
    if (i < 0) return 1'b0;
    if (lane == 0) begin
      if (i / 8 >= q0.size()) return 1'b0;
      b = q0[i / 8];
    end else begin
      if (i / 8 >= q1.size()) return 1'b0;
      b = q1[i / 8];
    end
    return b[7 - (i % 8)];
  endfunction
  task automatic tick();
    @(posedge clk_32f);
    #1;
  endtask
  task automatic fill(input int k, input logic [7:0] b0, input logic [7:0] b1);
    for (int j = 0; j < k; j++) begin
      q0.push_back(b0);
      q1.push_back(b1);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    data_in_0 = 1'b0;
    data_in_1 = 1'b0;
    tick();
    tick();
    chk("reset_outputs", outs(), 32'd0);
    reset = 1'b0;
    q0.delete();
    q1.delete();
  endtask
  task automatic run(input int id, input int len, input int skew);
    for (int n = 1; n <= len; n++) begin
      data_in_0 = bit_at(0, n - 1);
      data_in_1 = bit_at(1, n - 1 - skew);
      tick();
      foreach (vec[j])
        if (vec[j].id == id && vec[j].n == n)
          chk($sformatf("t%0d_edge%0d", id, n), outs(),
              {3'b0, vec[j].lock, vec[j].link, vec[j].stb, vec[j].sym, vec[j].dv, vec[j].err});
    end
  endtask
  initial begin
    // id, edge, lock, link, strobe, sym_out, valid, err
    add(1, 32, 2'b00, 0, 0, 16'h0000, 0, 0);
    add(1, 33, 2'b11, 1, 0, 16'h0000, 0, 0);
    add(1, 40, 2'b11, 1, 0, 16'h0000, 0, 0);
    add(1, 41, 2'b11, 1, 1, 16'hBCBC, 0, 0);
    add(1, 42, 2'b11, 1, 0, 16'hBCBC, 0, 0);
    add(1, 49, 2'b11, 1, 1, 16'hBCBC, 0, 0);
    add(1, 89, 2'b11, 1, 1, 16'hBCBC, 0, 0);
    add(5, 32, 2'b00, 0, 0, 16'h0000, 0, 0);
    add(5, 33, 2'b11, 1, 0, 16'h0000, 0, 0);
    add(5, 40, 2'b11, 1, 0, 16'h0000, 0, 0);
    add(2, 33, 2'b01, 0, 0, 16'h0000, 0, 0);
    add(2, 35, 2'b01, 0, 0, 16'h0000, 0, 0);
    add(2, 36, 2'b11, 1, 0, 16'h0000, 0, 0);
    add(2, 41, 2'b11, 1, 1, 16'hBCBC, 0, 0);
    add(2, 49, 2'b11, 1, 1, 16'hBC5A, 0, 0);
    add(2, 50, 2'b11, 1, 0, 16'hBC5A, 0, 0);
    add(2, 57, 2'b11, 1, 1, 16'hA55A, 1, 0);
    add(2, 58, 2'b11, 1, 0, 16'hA55A, 0, 0);
    add(2, 65, 2'b11, 1, 1, 16'hA55A, 1, 0);
    add(2, 73, 2'b11, 1, 1, 16'hA5BC, 0, 0);
    add(3, 41, 2'b11, 1, 1, 16'hBCBC, 0, 0);
    add(3, 49, 2'b11, 1, 1, 16'hBC00, 0, 0);
    add(3, 161, 2'b11, 1, 1, 16'hBC00, 0, 0);
    add(3, 168, 2'b11, 1, 0, 16'hBC00, 0, 0);
    add(3, 169, 2'b10, 0, 0, 16'hBC00, 0, 1);
    add(3, 177, 2'b10, 0, 0, 16'hBC00, 0, 1);
    add(4, 25, 2'b00, 0, 0, 16'h0000, 0, 0);
    add(4, 33, 2'b10, 0, 0, 16'h0000, 0, 0);
    add(4, 56, 2'b10, 0, 0, 16'h0000, 0, 0);
    add(4, 57, 2'b11, 1, 0, 16'h0000, 0, 0);
    add(4, 64, 2'b11, 1, 0, 16'h0000, 0, 0);
    add(4, 65, 2'b11, 1, 1, 16'hBCBC, 0, 0);
    do_reset();
    for (int c = 1; c <= 64; c++) begin
      tick();
      if (c % 16 == 0) chk($sformatf("idle_cycle%0d", c), outs(), 32'd0);
    end
    do_reset();
    fill(12, 8'hBC, 8'hBC);
    run(1, 96, 0);
    reset = 1'b1;
    tick();
    chk("midop_reset_outputs", outs(), 32'd0);
    reset = 1'b0;
    run(5, 40, 0);
    do_reset();
    fill(5, 8'hBC, 8'hBC);
    fill(3, 8'h5A, 8'hA5);
    fill(4, 8'hBC, 8'hBC);
    run(2, 100, 3);
    do_reset();
    fill(5, 8'hBC, 8'hBC);
    fill(20, 8'h00, 8'hBC);
    run(3, 180, 0);
    do_reset();
    fill(2, 8'hBC, 8'hBC);
    fill(1, 8'hBD, 8'hBC);
    fill(9, 8'hBC, 8'hBC);
    run(4, 80, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/phy_rx_link_ctrl.md
# phy_rx_link_ctrl

Receive-side link controller for the two-lane PHY receive path, clocked on the serial bit clock `clk_32f`. It tracks the serial bits on `data_in_0`/`data_in_1`, finds COM-symbol boundaries per lane and runs a per-lane lock state machine. It declares `link_up` when both lanes are locked, and emits a paired 16-bit symbol stream with a strobe and a data-valid qualifier. Downstream gating of `valid_out` in the receive datapath uses these outputs.

## Interface
Parameters:
- `COM_SYMBOL`, 8'hBC: comma/alignment symbol.
- `LOCK_COUNT`, 4: consecutive boundary-aligned COMs required to lock a lane (≥2).
- `MAX_GAP`, 16: maximum symbols between COMs on a locked lane before lock is dropped.

Ports:
- `clk_32f`, input, 1: serial bit clock; the only clock.
- `reset`, input, 1: synchronous, active-high.
- `data_in_0`, input, 1: lane 0 serial bit, MSB first.
- `data_in_1`, input, 1: lane 1 serial bit, MSB first.
- `lock`, output, 2: per-lane locked flag; bit i is lane i.
- `link_up`, output, 1: both lanes locked.
- `sym_strobe`, output, 1: one-cycle pulse at each lane-0 symbol boundary while `link_up`.
- `sym_out`, output, 16: {lane1 symbol, lane0 symbol}; valid at `sym_strobe`.
- `data_valid`, output, 1: `sym_strobe` and neither symbol equals `COM_SYMBOL`.
- `err_cnt`, output, 8: saturating count of lock losses, summed over both lanes.

## Operation
- Per lane, each cycle: `sr <= {sr[6:0], data_in}`.
- Per lane, a 3-bit phase counter `bit_cnt`. A boundary is the cycle where `bit_cnt==7` and `sr` is examined.
- Per-lane FSM states:
  - SEARCH: bit-by-bit compare; on `sr==COM_SYMBOL`, set `bit_cnt<=0` and `com_cnt<=1`, then go to ALIGN.
  - ALIGN: at each boundary, COM increments `com_cnt`. When `com_cnt` reaches `LOCK_COUNT`, go to LOCKED and set `gap_cnt<=0`. A non-COM symbol at a boundary returns to SEARCH with `com_cnt<=0`.
  - LOCKED: at each boundary, COM clears `gap_cnt`; any other symbol increments it. When `gap_cnt` reaches `MAX_GAP`, go to SEARCH and increment `err_cnt`, saturating at 8'hFF.
- `lock[i]` is high exactly when lane i is in LOCKED.
- At each lane boundary, the lane captures `sr` into its symbol register `sym_i`.
- `link_up = &lock`.
- At a lane-0 boundary with `link_up`, `sym_out <= {sym_1, sr_lane0}`. The lane-1 value is its most recently captured symbol; inter-lane skew is tolerated up to 7 bits.
- Both lanes losing lock on the same cycle increments `err_cnt` by 2, saturating.

## Timing
- Reset values: all outputs 0; FSMs in SEARCH; `sr`, `bit_cnt`, `com_cnt`, `gap_cnt`, and symbol registers 0.
- Reset mid-operation returns everything to reset values on the next edge, regardless of state.
- COM detected in SEARCH at cycle t: the first ALIGN boundary is at t+8. With LOCK_COUNT=4, `lock[i]` rises at t+25, i.e. registered one cycle after the t+24 boundary.
- `sym_strobe`, `sym_out` and `data_valid` are registered and appear one cycle after the lane-0 boundary.
- `link_up` follows the `lock` register combinationally, with no extra cycle.
- A strobe is never issued in the cycle `link_up` falls. If lane 0 drops lock at the same boundary it would strobe, no strobe is issued.
- In SEARCH, a COM that straddles a false boundary is accepted; the ALIGN confirmation rejects it.

## Structure
- Shared package `phy_rx_pkg`:
  - `COM_SYMBOL` default;
  - lane FSM state encoding (`ST_SEARCH`=2'd0, `ST_ALIGN`=2'd1, `ST_LOCKED`=2'd2);
  - symbol width constant 8.
- Sub-module `phy_rx_lane_align`, instantiated twice:
  - contains `sr`, `bit_cnt`, the FSM, `com_cnt` and `gap_cnt`;
  - outputs `locked`, `boundary`, `sym`, and a `lost` pulse.
- Top level: `link_up`, symbol pairing, strobe/valid registers and `err_cnt` saturation.

## Test plan
- Reset held, then released with both lanes idle at 0 → all outputs stay 0 and `lock`=2'b00 indefinitely.
- Both lanes send continuous 8'hBC with no skew → `lock`=2'b11 at 25 cycles after first detection. `sym_strobe` then pulses every 8 cycles with `sym_out`=16'hBCBC and `data_valid`=0.
- Lock both lanes, then send data 8'h5A on lane 0 and 8'hA5 on lane 1, lane 1 delayed 3 bits → `sym_out`=16'hA55A with `data_valid`=1 once per symbol.
- Locked lane 0 receives 16 consecutive non-COM symbols → `lock[0]` falls, `link_up` falls, no strobe on that boundary, `err_cnt`=1.
- In ALIGN after 2 COMs, inject one corrupt symbol 8'hBD at the boundary → lane returns to SEARCH and relocks only after 4 fresh COMs.
- Assert `reset` for one cycle while locked → all outputs 0 the next cycle, and relock takes the full 25 cycles.
